// File: rtl/int_alu_pkg.sv
// int_alu_pkg: opcodes, FSM states and opcode classification helpers for int_alu_sched
package int_alu_pkg;
  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_EQ, OP_NE, OP_GE, OP_GT, OP_LE, OP_LT, OP_LNOT,
    OP_BNOT, OP_MUL, OP_DIV, OP_MOD, OP_SHL, OP_ASHL, OP_SHR, OP_ASHR
  } alu_op_t;
  typedef enum logic [1:0] {IDLE, MUL, DIV, RESP} state_t;
  function automatic logic is_illegal(input logic [4:0] op);
    return op > OP_ASHR;
  endfunction
  function automatic logic is_single_cycle(input logic [4:0] op);
    return op <= OP_BNOT || (op >= OP_SHL && !is_illegal(op));
  endfunction
endpackage

// File: rtl/int_alu_sched_if.sv
// int_alu_sched_if: request/response bundle between requesters and the shared ALU scheduler
interface int_alu_sched_if #(parameter int NREQ = 2, parameter int W = 32);
  localparam int ID_W = $clog2(NREQ);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ-1:0][4:0] req_op;
  logic [NREQ-1:0][W-1:0] req_a;
  logic [NREQ-1:0][W-1:0] req_b;
  logic resp_valid;
  logic resp_ready;
  logic [ID_W-1:0] resp_id;
  logic [W-1:0] resp_data;
  logic resp_err;
  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input req_ready, resp_valid, resp_id, resp_data, resp_err
  );
  modport slave (
    input req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_data, resp_err
  );
endinterface

// File: rtl/int_alu_div.sv
// int_alu_div: W-cycle restoring signed divider; quotient truncates toward zero, remainder follows a
module int_alu_div #(parameter int W = 32) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic busy,
  output logic done,
  output logic [W-1:0] quot,
  output logic [W-1:0] rem
);
  localparam int CW = $clog2(W);
  logic [CW-1:0] cnt;
  logic [W-1:0] r, q, bm, r_nxt, q_nxt;
  logic [W:0] rs, diff;
  logic neg_q, neg_r, ok;
  assign rs = {r, q[W-1]};
  assign diff = rs - {1'b0, bm};
  assign ok = !diff[W];
  assign r_nxt = ok ? diff[W-1:0] : rs[W-1:0];
  assign q_nxt = {q[W-2:0], ok};
  // results come straight from the final step so the caller can register them on the last cycle
  assign done = busy && cnt == CW'(W - 1);
  assign quot = neg_q ? -q_nxt : q_nxt;
  assign rem = neg_r ? -r_nxt : r_nxt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      cnt <= '0;
      r <= '0;
      q <= '0;
      bm <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (start) begin
      busy <= 1'b1;
      cnt <= '0;
      r <= '0;
      q <= a[W-1] ? -a : a;
      bm <= b[W-1] ? -b : b;
      neg_q <= a[W-1] ^ b[W-1];
      neg_r <= a[W-1];
    end else if (busy) begin
      r <= r_nxt;
      q <= q_nxt;
      cnt <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/int_alu_sched.sv
// int_alu_sched: round-robin sharing of one signed integer ALU among NREQ requesters
module int_alu_sched import int_alu_pkg::*; #(
  parameter int NREQ = 2,
  parameter int W = 32
) (
  input logic clk,
  input logic rst,
  int_alu_sched_if.slave bus
);
  localparam int ID_W = $clog2(NREQ);
  state_t state;
  logic [ID_W-1:0] ptr, gnt_id, j;
  logic found, alu_e, div_op, b_zero, div_start, div_busy, div_done;
  logic [4:0] g_op, op_q;
  logic [W-1:0] g_a, g_b, a_q, b_q, alu_d, prod, quot, rem;
  always_comb begin
    found = 1'b0;
    gnt_id = '0;
    j = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = ID_W'((int'(ptr) + k) % NREQ);
      if (bus.req_valid[j]) begin
        found = 1'b1;
        gnt_id = j;
      end
    end
  end
  assign g_op = bus.req_op[gnt_id];
  assign g_a = bus.req_a[gnt_id];
  assign g_b = bus.req_b[gnt_id];
  assign bus.req_ready = (state == IDLE && found) ? NREQ'(1) << gnt_id : '0;
  assign div_op = g_op == OP_DIV || g_op == OP_MOD;
  assign b_zero = g_b == '0;
  assign div_start = state == IDLE && found && div_op && !b_zero && !div_busy;
  assign prod = a_q * b_q;
  // shifts by >= W already yield zero / sign fill under SV shift semantics
  always_comb begin
    alu_d = '0;
    alu_e = 1'b0;
    case (g_op)
      OP_ADD: alu_d = g_a + g_b;
      OP_SUB: alu_d = g_a - g_b;
      OP_EQ: alu_d = W'(g_a == g_b);
      OP_NE: alu_d = W'(g_a != g_b);
      OP_GE: alu_d = W'($signed(g_a) >= $signed(g_b));
      OP_GT: alu_d = W'($signed(g_a) > $signed(g_b));
      OP_LE: alu_d = W'($signed(g_a) <= $signed(g_b));
      OP_LT: alu_d = W'($signed(g_a) < $signed(g_b));
      OP_LNOT: alu_d = W'(g_a == '0);
      OP_BNOT: alu_d = ~g_a;
      OP_MUL: ;
      OP_DIV: begin
        alu_d = '1;
        alu_e = 1'b1;
      end
      OP_MOD: begin
        alu_d = g_a;
        alu_e = 1'b1;
      end
      OP_SHL, OP_ASHL: alu_d = g_a << g_b;
      OP_SHR: alu_d = g_a >> g_b;
      OP_ASHR: alu_d = $signed(g_a) >>> g_b;
      default: alu_e = 1'b1;
    endcase
  end
  int_alu_div #(.W(W)) u_div (
    .clk(clk),
    .rst(rst),
    .start(div_start),
    .a(g_a),
    .b(g_b),
    .busy(div_busy),
    .done(div_done),
    .quot(quot),
    .rem(rem)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_id <= '0;
      bus.resp_data <= '0;
      bus.resp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (found) begin
          ptr <= gnt_id == ID_W'(NREQ - 1) ? '0 : gnt_id + 1'b1;
          op_q <= g_op;
          a_q <= g_a;
          b_q <= g_b;
          bus.resp_id <= gnt_id;
          if (is_single_cycle(g_op) || is_illegal(g_op) || (div_op && b_zero)) begin
            bus.resp_data <= alu_d;
            bus.resp_err <= alu_e;
            bus.resp_valid <= 1'b1;
            state <= RESP;
          end else state <= g_op == OP_MUL ? MUL : DIV;
        end
        MUL: begin
          bus.resp_data <= prod;
          bus.resp_err <= 1'b0;
          bus.resp_valid <= 1'b1;
          state <= RESP;
        end
        DIV: if (div_done) begin
          bus.resp_data <= op_q == OP_MOD ? rem : quot;
          bus.resp_err <= 1'b0;
          bus.resp_valid <= 1'b1;
          state <= RESP;
        end
        RESP: if (bus.resp_ready) begin
          bus.resp_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_int_alu_sched.sv
// tb_int_alu_sched: directed + randomized checks of int_alu_sched against a behavioural model
module tb_int_alu_sched;
  localparam int NREQ = 2;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  int exp_ptr = 0;
  always #5 clk = ~clk;
  int_alu_sched_if #(.NREQ(NREQ), .W(W)) bus();
  int_alu_sched #(.NREQ(NREQ), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic void ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] d, output logic e);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    d = 32'd0;
    e = 1'b0;
    case (op)
      5'd0: d = a + b;
      5'd1: d = a - b;
      5'd2: d = {31'd0, a == b};
      5'd3: d = {31'd0, a != b};
      5'd4: d = {31'd0, sa >= sb};
      5'd5: d = {31'd0, sa > sb};
      5'd6: d = {31'd0, sa <= sb};
      5'd7: d = {31'd0, sa < sb};
      5'd8: d = {31'd0, a == 32'd0};
      5'd9: d = ~a;
      5'd10: d = 32'(sa * sb);
      5'd11: if (b == 0) begin d = 32'hFFFF_FFFF; e = 1'b1; end else d = 32'(sa / sb);
      5'd12: if (b == 0) begin d = a; e = 1'b1; end else d = 32'(sa % sb);
      5'd13, 5'd14: d = (b >= 32) ? 32'd0 : a << b[4:0];
      5'd15: d = (b >= 32) ? 32'd0 : a >> b[4:0];
      5'd16: d = (b >= 32) ? {32{a[31]}} : 32'(sa >>> b[4:0]);
      default: e = 1'b1;
    endcase
  endfunction
  function automatic int exp_lat(input logic [4:0] op, input logic [31:0] b);
    if (op == 5'd10) return 2;
    if ((op == 5'd11 || op == 5'd12) && b != 0) return W + 1;
    return 1;
  endfunction
  task automatic do_op(input int id, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ed, input logic ee);
    int lat;
    bit got;
    bus.req_op[id] = op;
    bus.req_a[id] = a;
    bus.req_b[id] = b;
    bus.req_valid[id] = 1'b1;
    #1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) if (bus.req_ready[id]) got = 1'b1; else tick();
    check($sformatf("grant id%0d op%0d", id, op), 64'(got), 64'd1);
    if (!got) begin
      bus.req_valid[id] = 1'b0;
      return;
    end
    tick();
    bus.req_valid[id] = 1'b0;
    exp_ptr = (id + 1) % NREQ;
    lat = 1;
    while (!bus.resp_valid && lat < 60) begin
      tick();
      lat++;
    end
    check($sformatf("latency op%0d", op), 64'(lat), 64'(exp_lat(op, b)));
    check($sformatf("data op%0d a=%0h b=%0h", op, a, b), 64'(bus.resp_data), 64'(ed));
    check($sformatf("err op%0d", op), 64'(bus.resp_err), 64'(ee));
    check($sformatf("id op%0d", op), 64'(bus.resp_id), 64'(id));
    tick();
  endtask
  task automatic rand_op(input int id, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    logic e;
    ref_alu(op, a, b, d, e);
    do_op(id, op, a, b, d, e);
  endtask
  initial begin
    int ng, ex;
    bit seen;
    logic [31:0] ra, rb;
    bus.req_valid = '0;
    bus.req_op = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset req_ready", 64'(bus.req_ready), 64'd0);
    check("reset resp_valid", 64'(bus.resp_valid), 64'd0);
    check("reset resp_id", 64'(bus.resp_id), 64'd0);
    check("reset resp_data", 64'(bus.resp_data), 64'd0);
    check("reset resp_err", 64'(bus.resp_err), 64'd0);
    rst = 1'b0;
    tick();
    do_op(0, 5'd0, 32'd42, 32'd19, 32'd61, 1'b0);
    do_op(0, 5'd1, 32'd42, 32'd19, 32'd23, 1'b0);
    do_op(0, 5'd2, 32'd42, 32'd19, 32'd0, 1'b0);
    do_op(0, 5'd3, 32'd42, 32'd19, 32'd1, 1'b0);
    do_op(0, 5'd4, 32'd42, 32'd19, 32'd1, 1'b0);
    do_op(0, 5'd5, 32'd42, 32'd19, 32'd1, 1'b0);
    do_op(0, 5'd6, 32'd42, 32'd19, 32'd0, 1'b0);
    do_op(0, 5'd7, 32'd42, 32'd19, 32'd0, 1'b0);
    do_op(0, 5'd8, 32'd42, 32'd19, 32'd0, 1'b0);
    do_op(0, 5'd9, 32'd42, 32'd19, 32'hFFFF_FFD5, 1'b0);
    do_op(0, 5'd10, 32'd42, 32'd19, 32'd798, 1'b0);
    do_op(0, 5'd11, 32'd42, 32'd19, 32'd2, 1'b0);
    do_op(0, 5'd12, 32'd42, 32'd19, 32'd4, 1'b0);
    do_op(0, 5'd13, 32'd42, 32'd19, 32'd22020096, 1'b0);
    do_op(0, 5'd14, 32'd42, 32'd19, 32'd22020096, 1'b0);
    do_op(0, 5'd15, 32'd42, 32'd19, 32'd0, 1'b0);
    do_op(0, 5'd16, 32'd42, 32'd19, 32'd0, 1'b0);
    do_op(1, 5'd11, -32'sd7, 32'd2, -32'sd3, 1'b0);
    do_op(1, 5'd12, -32'sd7, 32'd2, -32'sd1, 1'b0);
    do_op(1, 5'd11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    do_op(1, 5'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);
    do_op(0, 5'd16, -32'sd8, 32'd40, 32'hFFFF_FFFF, 1'b0);
    do_op(0, 5'd13, 32'd1, 32'd32, 32'd0, 1'b0);
    do_op(1, 5'd11, 32'd42, 32'd0, 32'hFFFF_FFFF, 1'b1);
    do_op(1, 5'd12, 32'd5, 32'd0, 32'd5, 1'b1);
    do_op(0, 5'd20, 32'd42, 32'd19, 32'd0, 1'b1);
    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if ($urandom_range(0, 3) == 0) ra = $signed(ra) >>> 20;
      rand_op(int'($urandom_range(0, 1)), 5'($urandom_range(0, 20)), ra, rb);
    end
    for (int i = 0; i < NREQ; i++) begin
      bus.req_op[i] = 5'd0;
      bus.req_a[i] = 32'(i);
      bus.req_b[i] = 32'd1;
    end
    bus.req_valid = '1;
    #1;
    ex = exp_ptr;
    ng = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.req_ready != 0) begin
        check($sformatf("rr grant %0d", ng), 64'(bus.req_ready), 64'(1 << ex));
        ex = (ex + 1) % NREQ;
        ng++;
      end
      tick();
    end
    bus.req_valid = '0;
    exp_ptr = ex;
    check("rr grant count", 64'(ng), 64'd4);
    bus.resp_ready = 1'b0;
    bus.req_op[1] = 5'd10;
    bus.req_a[1] = 32'd6;
    bus.req_b[1] = 32'd7;
    bus.req_valid[1] = 1'b1;
    #1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) if (bus.req_ready[1]) seen = 1'b1; else tick();
    check("stall grant", 64'(seen), 64'd1);
    tick();
    bus.req_valid[1] = 1'b0;
    for (int i = 0; i < 10 && !bus.resp_valid; i++) tick();
    bus.req_op[0] = 5'd0;
    bus.req_a[0] = 32'd40;
    bus.req_b[0] = 32'd3;
    bus.req_valid[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("stall valid c%0d", c), 64'(bus.resp_valid), 64'd1);
      check($sformatf("stall data c%0d", c), 64'(bus.resp_data), 64'd42);
      check($sformatf("stall id c%0d", c), 64'(bus.resp_id), 64'd1);
      check($sformatf("stall block c%0d", c), 64'(bus.req_ready), 64'd0);
      tick();
    end
    bus.resp_ready = 1'b1;
    tick();
    check("post stall grant", 64'(bus.req_ready), 64'd1);
    tick();
    bus.req_valid[0] = 1'b0;
    check("post stall data", 64'(bus.resp_data), 64'd43);
    check("post stall valid", 64'(bus.resp_valid), 64'd1);
    tick();
    bus.req_op[0] = 5'd11;
    bus.req_a[0] = 32'd1000;
    bus.req_b[0] = 32'd7;
    bus.req_valid[0] = 1'b1;
    #1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) if (bus.req_ready[0]) seen = 1'b1; else tick();
    check("div grant", 64'(seen), 64'd1);
    tick();
    bus.req_valid[0] = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    #1;
    check("midrst resp_valid", 64'(bus.resp_valid), 64'd0);
    check("midrst resp_data", 64'(bus.resp_data), 64'd0);
    check("midrst resp_err", 64'(bus.resp_err), 64'd0);
    check("midrst resp_id", 64'(bus.resp_id), 64'd0);
    check("midrst req_ready", 64'(bus.req_ready), 64'd0);
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.resp_valid) seen = 1'b1;
      tick();
    end
    check("midrst no response", 64'(seen), 64'd0);
    bus.req_valid = 2'b11;
    #1;
    check("post rst both valid", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 2'b10;
    #1;
    check("post rst req1 only", 64'(bus.req_ready), 64'd2);
    bus.req_valid = '0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
